// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and the per-axis phase encoding for the VGA raster generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } phase_t;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    function automatic int axis_total(int display, int front, int sync, int back);
        return display + front + sync + back;
    endfunction

    localparam int H_TOTAL = axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL = axis_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by the timing generator and consumed by the colour path.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic       hsync;
    logic       vsync;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       visible;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
    phase_t     h_phase;
    phase_t     v_phase;

    modport master (
        output hsync, vsync, hpos, vpos, visible,
        output line_start, frame_start, frame_count,
        output h_phase, v_phase
    );

    modport slave (
        input hsync, vsync, hpos, vpos, visible,
        input line_start, frame_start, frame_count,
        input h_phase, v_phase
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACT/FP/SYN/BP phase FSM, advancing on step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [9:0] pos,
    output phase_t     phase,
    output phase_t     phase_nxt,
    output logic       wrap
);

    localparam int         TOTAL     = axis_total(DISPLAY, FRONT, SYNC, BACK);
    localparam logic [9:0] LAST      = 10'(TOTAL - 1);
    localparam logic [9:0] FP_START  = 10'(DISPLAY);
    localparam logic [9:0] SYN_START = 10'(DISPLAY + FRONT);
    localparam logic [9:0] BP_START  = 10'(DISPLAY + FRONT + SYNC);

    logic [9:0] pos_nxt;

    // phase_nxt is exported so the top can register sync/visible in step with pos.
    always_comb begin
        wrap      = step && (pos == LAST);
        pos_nxt   = pos;
        phase_nxt = phase;
        if (step) begin
            pos_nxt = wrap ? 10'd0 : pos + 10'd1;
            case (phase)
                PH_ACT:  if (pos_nxt == FP_START)  phase_nxt = PH_FP;
                PH_FP:   if (pos_nxt == SYN_START) phase_nxt = PH_SYN;
                PH_SYN:  if (pos_nxt == BP_START)  phase_nxt = PH_BP;
                PH_BP:   if (pos_nxt == 10'd0)     phase_nxt = PH_ACT;
                default: phase_nxt = PH_ACT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos   <= 10'd0;
            phase <= PH_ACT;
        end else begin
            pos   <= pos_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: hpos/vpos counters, aligned registered syncs/visible, line/frame strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY   = H_DISPLAY_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_DISPLAY   = V_DISPLAY_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    vga_timing_gen_if.master vga
);

    logic [9:0] h_pos, v_pos;
    phase_t     h_phase, h_phase_nxt, v_phase, v_phase_nxt;
    logic       h_wrap, v_wrap;

    logic       hsync_q, vsync_q, visible_q, line_start_q, frame_start_q;
    logic [7:0] frame_count_q;

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(en),
        .pos(h_pos), .phase(h_phase), .phase_nxt(h_phase_nxt), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(h_wrap),
        .pos(v_pos), .phase(v_phase), .phase_nxt(v_phase_nxt), .wrap(v_wrap)
    );

    // Decoding next phases keeps sync/visible on the same pixel as the counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            visible_q     <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            hsync_q       <= (h_phase_nxt == PH_SYN) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q       <= (v_phase_nxt == PH_SYN) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            visible_q     <= (h_phase_nxt == PH_ACT) && (v_phase_nxt == PH_ACT);
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (v_wrap) frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.hpos        = h_pos;
    assign vga.vpos        = v_pos;
    assign vga.visible     = visible_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;
    assign vga.h_phase     = h_phase;
    assign vga.v_phase     = v_phase;

endmodule
